// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Register ranks are spread evenly across the prefix levels; the last rank holds the result.
module prefix_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam int LAST = STAGES - 1;

  // Handshake state, one bit per rank (index 0 = rank 1).
  logic [STAGES-1:0] v_q, v_d, rdy, up_v, ld;

  // Data entering each combinational segment: index 0 comes from the ports,
  // index s>0 from the register rank in front of segment s.
  logic [WIDTH-1:0] sg_g   [STAGES];
  logic [WIDTH-1:0] sg_p   [STAGES];
  logic [WIDTH-1:0] sg_pin [STAGES];
  logic             sg_c0  [STAGES];
  logic [TAG_W-1:0] sg_tag [STAGES];
  logic [WIDTH-1:0] so_g   [STAGES];
  logic [WIDTH-1:0] so_p   [STAGES];

  logic [WIDTH-1:0] b_eff, g_init, p_init;
  logic             c0;

  always_comb begin
    b_eff  = in_sub ? ~in_b : in_b;
    c0     = in_sub | in_cin;
    g_init = in_a & b_eff;
    p_init = in_a ^ b_eff;
    // Carry-in becomes part of bit 0's generate, so the tree spans only WIDTH bits.
    g_init[0] = g_init[0] | (p_init[0] & c0);
  end

  assign sg_g[0]   = g_init;
  assign sg_p[0]   = {p_init[WIDTH-1:1], 1'b0};
  assign sg_pin[0] = p_init;
  assign sg_c0[0]  = c0;
  assign sg_tag[0] = in_tag;

  // A rank can take new data when it or any rank downstream of it is empty,
  // or the consumer is draining the output.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_ctrl
    if (gi == 0) begin : g_first
      assign up_v[gi] = in_valid;
    end else begin : g_next
      assign up_v[gi] = v_q[gi-1];
    end
    assign rdy[gi] = out_ready | ~(&v_q[STAGES-1:gi]);
    assign ld[gi]  = rdy[gi] & up_v[gi];
    assign v_d[gi] = rdy[gi] ? up_v[gi] : v_q[gi];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_seg
    localparam int LO = (gi * LEVELS) / STAGES;
    localparam int HI = ((gi + 1) * LEVELS) / STAGES;

    logic [WIDTH-1:0] acc_g, acc_p;

    // Prefix levels LO+1..HI; level k+1 combines each bit with the group 2^k below it.
    always_comb begin
      acc_g = sg_g[gi];
      acc_p = sg_p[gi];
      for (int k = LO; k < HI; k++) begin
        acc_g = acc_g | (acc_p & (acc_g << (1 << k)));
        acc_p = acc_p & ((acc_p << (1 << k)) | ~(ONES << (1 << k)));
      end
    end

    assign so_g[gi] = acc_g;
    assign so_p[gi] = acc_p;

    if (gi < LAST) begin : g_mid
      logic [WIDTH-1:0] g_q, g_d, p_q, p_d, pin_q, pin_d;
      logic             c0_q, c0_d;
      logic [TAG_W-1:0] tag_q, tag_d;

      always_comb begin
        g_d   = g_q;
        p_d   = p_q;
        pin_d = pin_q;
        c0_d  = c0_q;
        tag_d = tag_q;
        if (ld[gi]) begin
          g_d   = acc_g;
          p_d   = acc_p;
          pin_d = sg_pin[gi];
          c0_d  = sg_c0[gi];
          tag_d = sg_tag[gi];
        end
      end

      always_ff @(posedge clk) begin
        g_q   <= g_d;
        p_q   <= p_d;
        pin_q <= pin_d;
        c0_q  <= c0_d;
        tag_q <= tag_d;
      end

      assign sg_g[gi+1]   = g_q;
      assign sg_p[gi+1]   = p_q;
      assign sg_pin[gi+1] = pin_q;
      assign sg_c0[gi+1]  = c0_q;
      assign sg_tag[gi+1] = tag_q;
    end
  end

  logic [WIDTH-1:0] fin_g, carries;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d, out_ovf_q, out_ovf_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  // Final group generates are the carries out of each bit.
  assign fin_g   = so_g[LAST];
  assign carries = {fin_g[WIDTH-2:0], sg_c0[LAST]};

  always_comb begin
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;
    out_tag_d  = out_tag_q;
    if (ld[LAST]) begin
      out_sum_d  = sg_pin[LAST] ^ carries;
      out_cout_d = fin_g[WIDTH-1];
      out_ovf_d  = fin_g[WIDTH-1] ^ fin_g[WIDTH-2];
      out_tag_d  = sg_tag[LAST];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
      out_tag_q  <= '0;
    end else begin
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
      out_tag_q  <= out_tag_d;
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[LAST];
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Directed and randomized checks of prefix_adder_pipe at three parameter points.
// Main instance 8b/2 ranks; sweep instances 64b/7 ranks and 7b/1 rank.
module tb_prefix_adder_pipe;

  localparam int W64_S = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // main instance
  logic       m_in_valid, m_in_ready, m_in_cin, m_in_sub, m_out_valid, m_out_ready;
  logic       m_out_cout, m_out_ovf;
  logic [7:0] m_in_a, m_in_b, m_out_sum;
  logic [3:0] m_in_tag, m_out_tag;

  // sweep instances
  logic        w64_in_valid, w64_in_ready, w64_in_cin, w64_in_sub, w64_out_valid, w64_out_ready;
  logic        w64_out_cout, w64_out_ovf;
  logic [63:0] w64_in_a, w64_in_b, w64_out_sum;
  logic [3:0]  w64_in_tag, w64_out_tag;
  logic        w7_in_valid, w7_in_ready, w7_in_cin, w7_in_sub, w7_out_valid, w7_out_ready;
  logic        w7_out_cout, w7_out_ovf;
  logic [6:0]  w7_in_a, w7_in_b, w7_out_sum;
  logic [3:0]  w7_in_tag, w7_out_tag;

  prefix_adder_pipe #(.WIDTH(8), .STAGES(2), .TAG_W(4)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready),
    .in_a(m_in_a), .in_b(m_in_b), .in_cin(m_in_cin), .in_sub(m_in_sub), .in_tag(m_in_tag),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .out_sum(m_out_sum),
    .out_cout(m_out_cout), .out_ovf(m_out_ovf), .out_tag(m_out_tag));

  prefix_adder_pipe #(.WIDTH(64), .STAGES(W64_S), .TAG_W(4)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w64_in_valid), .in_ready(w64_in_ready),
    .in_a(w64_in_a), .in_b(w64_in_b), .in_cin(w64_in_cin), .in_sub(w64_in_sub), .in_tag(w64_in_tag),
    .out_valid(w64_out_valid), .out_ready(w64_out_ready), .out_sum(w64_out_sum),
    .out_cout(w64_out_cout), .out_ovf(w64_out_ovf), .out_tag(w64_out_tag));

  prefix_adder_pipe #(.WIDTH(7), .STAGES(1), .TAG_W(4)) u_w7 (
    .clk(clk), .rst_n(rst_n), .in_valid(w7_in_valid), .in_ready(w7_in_ready),
    .in_a(w7_in_a), .in_b(w7_in_b), .in_cin(w7_in_cin), .in_sub(w7_in_sub), .in_tag(w7_in_tag),
    .out_valid(w7_out_valid), .out_ready(w7_out_ready), .out_sum(w7_out_sum),
    .out_cout(w7_out_cout), .out_ovf(w7_out_ovf), .out_tag(w7_out_tag));

  typedef struct {
    logic [7:0] a, b;
    logic       cin, sub;
    logic [3:0] tag;
    logic [7:0] s;
    logic       c, o;
  } vec_t;

  typedef struct {
    logic [65:0] res;
    logic [3:0]  tag;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  // Independent reference: plain wide addition, returns {ovf, cout, sum[63:0]}.
  function automatic logic [65:0] ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                           input logic cin, input logic sub);
    logic [65:0] mask, aa, bb, r, t;
    logic c0, cout, ovf, sa, sb, ss;
    mask = (66'd1 << w) - 66'd1;
    aa   = {2'b00, a} & mask;
    bb   = (sub ? ~{2'b00, b} : {2'b00, b}) & mask;
    c0   = sub ? 1'b1 : cin;
    r    = aa + bb + {65'd0, c0};
    t = r >> w;        cout = t[0];
    t = aa >> (w - 1); sa = t[0];
    t = bb >> (w - 1); sb = t[0];
    t = r >> (w - 1);  ss = t[0];
    ovf = (sa == sb) && (ss != sa);
    r = r & mask;
    return {ovf, cout, r[63:0]};
  endfunction

  task automatic idle_all();
    m_in_valid = 0; m_in_a = '0; m_in_b = '0; m_in_cin = 0; m_in_sub = 0; m_in_tag = '0; m_out_ready = 1;
    w64_in_valid = 0; w64_in_a = '0; w64_in_b = '0; w64_in_cin = 0; w64_in_sub = 0; w64_in_tag = '0; w64_out_ready = 1;
    w7_in_valid = 0; w7_in_a = '0; w7_in_b = '0; w7_in_cin = 0; w7_in_sub = 0; w7_in_tag = '0; w7_out_ready = 1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if (m_in_ready !== 1'b1 || m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: in_ready=%b out_valid=%b, required 1 0", m_in_ready, m_out_valid);
    end
    checks++;
    if ({m_out_sum, m_out_cout, m_out_ovf, m_out_tag} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: sum=%h cout=%b ovf=%b tag=%h, required all 0",
               m_out_sum, m_out_cout, m_out_ovf, m_out_tag);
    end
    checks++;
    if (w64_out_valid !== 1'b0 || w7_out_valid !== 1'b0 || w64_in_ready !== 1'b1 || w7_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_sweep_duts: w64 v/r=%b%b w7 v/r=%b%b, required 01 01",
               w64_out_valid, w64_in_ready, w7_out_valid, w7_in_ready);
    end
    $display("reset: in_ready=%b out_valid=%b sum=%h tag=%h", m_in_ready, m_out_valid, m_out_sum, m_out_tag);
  endtask

  task automatic test_vectors();
    vec_t v[8];
    v[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 4'd3, 8'h00, 1'b1, 1'b0};
    v[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 4'd1, 8'h80, 1'b0, 1'b1};
    v[2] = '{8'h80, 8'h01, 1'b0, 1'b1, 4'd2, 8'h7F, 1'b1, 1'b1};
    v[3] = '{8'h00, 8'h01, 1'b0, 1'b1, 4'd4, 8'hFF, 1'b0, 1'b0};
    v[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 4'd5, 8'h47, 1'b0, 1'b0};
    v[5] = '{8'h10, 8'h10, 1'b0, 1'b1, 4'd6, 8'h00, 1'b1, 1'b0};
    v[6] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 4'd7, 8'hFF, 1'b1, 1'b0};
    v[7] = '{8'h80, 8'h80, 1'b0, 1'b0, 4'd9, 8'h00, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_out_ready = 1;
      m_in_valid = 1; m_in_a = v[i].a; m_in_b = v[i].b; m_in_cin = v[i].cin;
      m_in_sub = v[i].sub; m_in_tag = v[i].tag;
      #1;
      checks++;
      if (m_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL vec%0d_in_ready: got %b, required 1", i, m_in_ready);
      end
      @(negedge clk);
      m_in_valid = 0;
      #1;
      checks++;
      if (m_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_early_valid: out_valid=%b one cycle after accept, required 0", i, m_out_valid);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({m_out_valid, m_out_sum, m_out_cout, m_out_ovf, m_out_tag} !==
          {1'b1, v[i].s, v[i].c, v[i].o, v[i].tag}) begin
        errors++;
        $display("FAIL vec%0d_result: valid=%b sum=%h cout=%b ovf=%b tag=%h, required 1 %h %b %b %h",
                 i, m_out_valid, m_out_sum, m_out_cout, m_out_ovf, m_out_tag,
                 v[i].s, v[i].c, v[i].o, v[i].tag);
      end else begin
        $display("vec%0d: a=%h b=%h sub=%b -> sum=%h cout=%b ovf=%b tag=%h",
                 i, v[i].a, v[i].b, v[i].sub, m_out_sum, m_out_cout, m_out_ovf, m_out_tag);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int nexp = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    logic saw_ready;
    // Stall the consumer: only STAGES operations can be absorbed.
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      m_out_ready = 0;
      m_in_valid = 1; m_in_a = 8'(k); m_in_b = 8'h10; m_in_cin = 0; m_in_sub = 0; m_in_tag = 4'(k);
      #1;
      saw_ready = m_in_ready;
      if (saw_ready) k++;
    end
    checks++;
    if (k != 2 || saw_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_capacity: accepted %0d in_ready=%b, required 2 and 0", k, saw_ready);
    end
    checks++;
    if ({m_out_valid, m_out_sum, m_out_tag} !== {1'b1, 8'h10, 4'd0}) begin
      errors++;
      $display("FAIL stall_hold: valid=%b sum=%h tag=%h, required 1 10 0", m_out_valid, m_out_sum, m_out_tag);
    end
    $display("stall: accepted=%0d in_ready=%b held tag=%h", k, saw_ready, m_out_tag);
    // Release: full pipe accepts and retires in the same cycle, then streams.
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      m_out_ready = 1;
      m_in_valid = (k < 8);
      m_in_a = 8'(k); m_in_tag = 4'(k);
      #1;
      if (cyc == 0) begin
        checks++;
        if (m_in_ready !== 1'b1 || m_out_valid !== 1'b1) begin
          errors++;
          $display("FAIL full_accept_retire: in_ready=%b out_valid=%b, required 1 1", m_in_ready, m_out_valid);
        end
      end
      if (m_out_valid) begin
        checks++;
        if (m_out_tag !== 4'(nexp) || m_out_sum !== 8'(nexp + 16)) begin
          errors++;
          $display("FAIL stream_order: tag=%h sum=%h, required %h %h", m_out_tag, m_out_sum, 4'(nexp), 8'(nexp + 16));
        end else begin
          $display("stream: tag=%h sum=%h", m_out_tag, m_out_sum);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nexp++;
      end
      if (m_in_valid && m_in_ready) k++;
    end
    m_in_valid = 0;
    checks++;
    if (nexp != 8 || (last_cyc - first_cyc) != 7) begin
      errors++;
      $display("FAIL stream_count: results=%0d span=%0d cycles, required 8 and 7", nexp, last_cyc - first_cyc);
    end
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    m_out_ready = 0;
    m_in_valid = 1; m_in_a = 8'h11; m_in_b = 8'h22; m_in_sub = 0; m_in_cin = 0; m_in_tag = 4'd5;
    @(negedge clk);
    m_in_a = 8'h33; m_in_b = 8'h44; m_in_tag = 4'd6;
    @(negedge clk);
    m_in_valid = 0;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    checks++;
    if ({m_out_valid, m_out_sum, m_out_tag, m_in_ready} !== {1'b0, 8'h00, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_state: valid=%b sum=%h tag=%h in_ready=%b, required 0 00 0 1",
               m_out_valid, m_out_sum, m_out_tag, m_in_ready);
    end
    m_out_ready = 1;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (m_out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_discard: %0d stale results appeared, required 0", seen);
    end
    $display("reset_mid: flushed, stale results=%0d", seen);
  endtask

  task automatic test_sweep(input int which);
    int w, st;
    logic vld, orr, cin, sub, ov, ir, oc, oo;
    logic [63:0] a, b, osum;
    logic [3:0] tag, ot;
    exp_t e;
    w  = (which == 0) ? 64 : 7;
    st = (which == 0) ? W64_S : 1;
    exp_q.delete();
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clk);
      orr = (cyc < 60 || cyc >= 240) ? 1'b1 : 1'($urandom_range(0, 1));
      vld = (cyc < 220) && ($urandom_range(0, 3) != 0);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      tag = 4'($urandom_range(0, 15));
      if (which == 0) begin
        w64_out_ready = orr; w64_in_valid = vld; w64_in_a = a; w64_in_b = b;
        w64_in_cin = cin; w64_in_sub = sub; w64_in_tag = tag;
      end else begin
        w7_out_ready = orr; w7_in_valid = vld; w7_in_a = a[6:0]; w7_in_b = b[6:0];
        w7_in_cin = cin; w7_in_sub = sub; w7_in_tag = tag;
      end
      #1;
      ov   = (which == 0) ? w64_out_valid : w7_out_valid;
      ir   = (which == 0) ? w64_in_ready : w7_in_ready;
      osum = (which == 0) ? w64_out_sum : {57'd0, w7_out_sum};
      oc   = (which == 0) ? w64_out_cout : w7_out_cout;
      oo   = (which == 0) ? w64_out_ovf : w7_out_ovf;
      ot   = (which == 0) ? w64_out_tag : w7_out_tag;
      if (ov && orr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sweep_w%0d_spurious: result tag=%h with nothing in flight", w, ot);
        end else begin
          e = exp_q.pop_front();
          if ({oo, oc, osum, ot} !== {e.res, e.tag}) begin
            errors++;
            $display("FAIL sweep_w%0d_result: sum=%h cout=%b ovf=%b tag=%h, required %h %b %b %h",
                     w, osum, oc, oo, ot, e.res[63:0], e.res[64], e.res[65], e.tag);
          end else begin
            $display("sweep w%0d: sum=%h cout=%b ovf=%b tag=%h", w, osum, oc, oo, ot);
          end
          if (cyc < 60) begin
            checks++;
            if (cyc - e.acc != st) begin
              errors++;
              $display("FAIL sweep_w%0d_latency: %0d cycles, required %0d", w, cyc - e.acc, st);
            end
          end
        end
      end
      if (vld && ir) exp_q.push_back('{ref_calc(w, a, b, cin, sub), tag, cyc});
    end
    idle_all();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sweep_w%0d_lost: %0d results never emerged, required 0", w, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    repeat (4) @(negedge clk);
    test_reset_mid();
    test_sweep(0);
    test_sweep(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
